// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : IF lookup, EX resolution and redirect signals of the branch
//               predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_pc;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] branch_target;
    logic              branch_taken;
    logic              prediction_res;
    logic [ADDR_W-1:0] jumpaddr;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic [31:0]       branch_cnt;
    logic [31:0]       mispred_cnt;

    modport master (
        output rdy, if_pc, branch_flag, branch_pc, branch_target,
               branch_taken, prediction_res, jumpaddr,
        input  pred_taken, pred_pc, flush, flush_pc, branch_cnt, mispred_cnt
    );

    modport slave (
        input  rdy, if_pc, branch_flag, branch_pc, branch_target,
               branch_taken, prediction_res, jumpaddr,
        output pred_taken, pred_pc, flush, flush_pc, branch_cnt, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters, mispredict flush/redirect
//               controller and branch statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [1:0]  c_ctr_init = 2'b01;
    localparam logic [1:0]  c_ctr_alloc = 2'b10;
    localparam logic [1:0]  c_ctr_max  = 2'b11;
    localparam logic [1:0]  c_ctr_min  = 2'b00;
    localparam logic [31:0] c_cnt_max  = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    state_t            r_state;
    logic              r_flush;
    logic [ADDR_W-1:0] r_flush_pc;
    logic [31:0]       r_branch_cnt;
    logic [31:0]       r_mispred_cnt;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic              w_pred_taken;
    logic [IDX_W-1:0]  w_br_idx;
    logic [TAG_W-1:0]  w_br_tag;
    logic              w_br_hit;
    logic              w_unused_bits;

    // Fetch-side lookup reads the registered table only, so a same-cycle
    // update is not visible until the following cycle.
    assign w_if_idx     = bus.if_pc[IDX_W+1:2];
    assign w_if_tag     = bus.if_pc[ADDR_W-1:IDX_W+2];
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];

    assign w_br_idx = bus.branch_pc[IDX_W+1:2];
    assign w_br_tag = bus.branch_pc[ADDR_W-1:IDX_W+2];
    assign w_br_hit = r_valid[w_br_idx] && (r_tag[w_br_idx] == w_br_tag);

    assign w_unused_bits = ^{bus.if_pc[1:0], bus.branch_pc[1:0]};

    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_pc     = w_pred_taken ? r_target[w_if_idx] : bus.if_pc + ADDR_W'(4);
    assign bus.flush       = r_flush;
    assign bus.flush_pc    = r_flush_pc;
    assign bus.branch_cnt  = r_branch_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= c_ctr_init;
            end
            r_state       <= ST_IDLE;
            r_flush       <= 1'b0;
            r_flush_pc    <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (bus.rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.branch_flag) begin
                        if (w_br_hit) begin
                            if (bus.branch_taken) begin
                                if (r_ctr[w_br_idx] != c_ctr_max)
                                    r_ctr[w_br_idx] <= r_ctr[w_br_idx] + 2'd1;
                                r_target[w_br_idx] <= bus.branch_target;
                            end else if (r_ctr[w_br_idx] != c_ctr_min) begin
                                r_ctr[w_br_idx] <= r_ctr[w_br_idx] - 2'd1;
                            end
                        end else if (bus.branch_taken) begin
                            r_valid[w_br_idx]  <= 1'b1;
                            r_tag[w_br_idx]    <= w_br_tag;
                            r_target[w_br_idx] <= bus.branch_target;
                            r_ctr[w_br_idx]    <= c_ctr_alloc;
                        end

                        if (r_branch_cnt != c_cnt_max)
                            r_branch_cnt <= r_branch_cnt + 32'd1;

                        if (!bus.prediction_res) begin
                            if (r_mispred_cnt != c_cnt_max)
                                r_mispred_cnt <= r_mispred_cnt + 32'd1;
                            r_flush    <= 1'b1;
                            r_flush_pc <= bus.jumpaddr;
                            r_state    <= ST_FLUSH;
                        end
                    end
                end
                // Resolutions arriving while flushing come from the wrong path.
                ST_FLUSH: begin
                    r_flush <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed scoreboard bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    localparam int S_PT  = 0;
    localparam int S_PPC = 1;
    localparam int S_FL  = 2;
    localparam int S_FPC = 3;
    localparam int S_BC  = 4;
    localparam int S_MC  = 5;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       nm;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    branch_predictor_if #(.ADDR_W(32)) bus ();

    branch_predictor #(.ENTRIES(64), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    sb_item_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;
    int exp_bc   = 0;
    int exp_mc   = 0;

    function automatic logic [31:0] sample(int sig);
        case (sig)
            S_PT:    return {31'd0, bus.pred_taken};
            S_PPC:   return bus.pred_pc;
            S_FL:    return {31'd0, bus.flush};
            S_FPC:   return bus.flush_pc;
            S_BC:    return bus.branch_cnt;
            default: return bus.mispred_cnt;
        endcase
    endfunction

    task automatic push(int sig, logic [31:0] exp, string nm);
        sb_item_t it;
        it.sig = sig;
        it.exp = exp;
        it.nm  = nm;
        sb.push_back(it);
    endtask

    task automatic expect_pred(logic [31:0] pc, logic pt, logic [31:0] ppc, string nm);
        bus.if_pc = pc;
        push(S_PT, {31'd0, pt}, {nm, ".pred_taken"});
        push(S_PPC, ppc, {nm, ".pred_pc"});
    endtask

    task automatic expect_state(logic fl, logic [31:0] fpc, string nm);
        push(S_FL, {31'd0, fl}, {nm, ".flush"});
        push(S_FPC, fpc, {nm, ".flush_pc"});
        push(S_BC, exp_bc, {nm, ".branch_cnt"});
        push(S_MC, exp_mc, {nm, ".mispred_cnt"});
    endtask

    task automatic drain();
        sb_item_t it;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = sample(it.sig);
            n_assert++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.nm, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(logic [31:0] pc, logic [31:0] tgt, logic tk, logic res, logic [31:0] ja);
        bus.branch_flag    = 1'b1;
        bus.branch_pc      = pc;
        bus.branch_target  = tgt;
        bus.branch_taken   = tk;
        bus.prediction_res = res;
        bus.jumpaddr       = ja;
    endtask

    // One accepted resolution in IDLE with rdy high.
    task automatic resolve(logic [31:0] pc, logic [31:0] tgt, logic tk, logic res, logic [31:0] ja);
        drive_br(pc, tgt, tk, res, ja);
        tick();
        bus.branch_flag = 1'b0;
        exp_bc++;
        if (!res) exp_mc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rdy = 1'b1;
        bus.if_pc = 32'h0;
        drive_br(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        bus.branch_flag = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and pc+4 wrap
        expect_pred(32'h1000, 1'b0, 32'h1004, "reset");
        expect_state(1'b0, 32'h0, "reset");
        drain();
        expect_pred(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap");
        drain();

        // First taken mispredict; same-cycle lookup sees old table
        drive_br(32'h1000, 32'h0F00, 1'b1, 1'b0, 32'h0F00);
        expect_pred(32'h1000, 1'b0, 32'h1004, "samecyc");
        drain();
        tick();
        bus.branch_flag = 1'b0;
        exp_bc++; exp_mc++;
        expect_state(1'b1, 32'h0F00, "mis1");
        expect_pred(32'h1000, 1'b1, 32'h0F00, "alloc");
        drain();
        tick();
        expect_state(1'b0, 32'h0F00, "mis1_end");
        drain();

        // Not-taken training: ctr 2 -> 1 -> 0
        resolve(32'h1000, 32'h0F00, 1'b0, 1'b0, 32'h1004);
        expect_state(1'b1, 32'h1004, "nt1");
        expect_pred(32'h1000, 1'b0, 32'h1004, "nt1");
        drain();
        tick();
        resolve(32'h1000, 32'h0F00, 1'b0, 1'b1, 32'h1004);
        expect_state(1'b0, 32'h1004, "nt2");
        expect_pred(32'h1000, 1'b0, 32'h1004, "nt2");
        drain();

        // Taken training: 0 -> 1 -> 2 -> 3 -> 3, then one not-taken
        resolve(32'h1000, 32'h0F00, 1'b1, 1'b0, 32'h0F00);
        expect_pred(32'h1000, 1'b0, 32'h1004, "t1");
        drain();
        tick();
        resolve(32'h1000, 32'h0F00, 1'b1, 1'b0, 32'h0F00);
        expect_pred(32'h1000, 1'b1, 32'h0F00, "t2");
        drain();
        tick();
        resolve(32'h1000, 32'h2000, 1'b1, 1'b1, 32'h2000);
        expect_pred(32'h1000, 1'b1, 32'h2000, "t3");
        drain();
        resolve(32'h1000, 32'h2000, 1'b1, 1'b1, 32'h2000);
        resolve(32'h1000, 32'h0F00, 1'b0, 1'b0, 32'h1004);
        expect_state(1'b1, 32'h1004, "sat_nt");
        expect_pred(32'h1000, 1'b1, 32'h2000, "sat_nt");
        drain();
        tick();

        // Alias: same index, different tag
        expect_pred(32'h1100, 1'b0, 32'h1104, "alias");
        drain();

        // Back-to-back: resolution during FLUSH is dropped
        resolve(32'h1040, 32'h3000, 1'b1, 1'b0, 32'h3000);
        drive_br(32'h1080, 32'h4000, 1'b1, 1'b0, 32'h4000);
        expect_state(1'b1, 32'h3000, "b2b_n1");
        drain();
        tick();
        bus.branch_flag = 1'b0;
        expect_state(1'b0, 32'h3000, "b2b_n2");
        expect_pred(32'h1080, 1'b0, 32'h1084, "b2b_drop");
        drain();
        expect_pred(32'h1040, 1'b1, 32'h3000, "b2b_keep");
        drain();

        // rdy low across a mispredict: nothing captured
        bus.rdy = 1'b0;
        drive_br(32'h10C0, 32'h5000, 1'b1, 1'b0, 32'h5000);
        tick();
        tick();
        bus.branch_flag = 1'b0;
        expect_state(1'b0, 32'h3000, "rdy0");
        expect_pred(32'h10C0, 1'b0, 32'h10C4, "rdy0");
        drain();

        // rdy low while in FLUSH holds the flush pulse
        bus.rdy = 1'b1;
        resolve(32'h1100, 32'h6000, 1'b1, 1'b0, 32'h6000);
        bus.rdy = 1'b0;
        expect_state(1'b1, 32'h6000, "hold0");
        drain();
        tick();
        tick();
        expect_state(1'b1, 32'h6000, "hold2");
        drain();
        bus.rdy = 1'b1;
        push(S_FL, 32'h1, "hold_rdy.flush");
        drain();
        tick();
        expect_state(1'b0, 32'h6000, "hold_end");
        expect_pred(32'h1100, 1'b1, 32'h6000, "replace");
        drain();
        expect_pred(32'h1000, 1'b0, 32'h1004, "evicted");
        drain();

        // Reset during FLUSH, with rdy low
        resolve(32'h1040, 32'h3000, 1'b0, 1'b0, 32'h1044);
        expect_state(1'b1, 32'h1044, "pre_rst");
        drain();
        rst = 1'b1;
        bus.rdy = 1'b0;
        tick();
        rst = 1'b0;
        bus.rdy = 1'b1;
        exp_bc = 0;
        exp_mc = 0;
        expect_state(1'b0, 32'h0, "rst_flush");
        expect_pred(32'h1040, 1'b0, 32'h1044, "rst_clr");
        drain();
        expect_pred(32'h1100, 1'b0, 32'h1104, "rst_clr2");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Branch prediction and redirect controller for the five-stage RISC-V pipeline. It gives IF a next-PC prediction from a direct-mapped branch target buffer with 2-bit saturating counters, and trains on the resolution signals from EX. On a misprediction it raises a one-cycle registered flush with the corrected PC for PC/IF/ID, and it keeps branch and mispredict statistics.

## Interface
- ENTRIES, 64, number of BTB entries (power of two, ≥4); IDX_W = log2(ENTRIES)
- ADDR_W, 32, PC width; TAG_W = ADDR_W − IDX_W − 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; 0 freezes all state (no update, no FSM transition)
- if_pc  in  ADDR_W  PC being fetched
- pred_taken  out  1  combinational; BTB hit and counter[1]==1
- pred_pc  out  ADDR_W  combinational; hit-entry target if pred_taken, else if_pc+4
- branch_flag  in  1  EX holds a branch/jump this cycle
- branch_pc  in  ADDR_W  PC of the resolving instruction
- branch_target  in  ADDR_W  computed target
- branch_taken  in  1  actual direction
- prediction_res  in  1  1 = prediction correct, 0 = mispredicted
- jumpaddr  in  ADDR_W  correct next PC
- flush  out  1  registered; squash the wrong-path IF/ID/ID-EX contents
- flush_pc  out  ADDR_W  registered; PC to restart fetch from
- branch_cnt  out  32  resolved branches counted
- mispred_cnt  out  32  mispredictions counted

## Operation
- Entry fields: valid, tag[TAG_W], target[ADDR_W], ctr[2].
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Hit = valid && tag match.
- Lookup is combinational on if_pc from the registered table. A miss gives pred_taken=0 and pred_pc=if_pc+4. The add wraps modulo 2^ADDR_W.
- FSM states:
  - IDLE: an update is accepted when rdy && branch_flag.
    - Hit: ctr += 1 if taken (saturates at 3), ctr −= 1 if not taken (saturates at 0). If taken, the target is overwritten with branch_target.
    - Miss, taken: allocate/replace the entry with valid=1, tag, target=branch_target, ctr=2'b10.
    - Miss, not taken: the table is unchanged.
    - branch_cnt += 1.
    - If prediction_res==0: mispred_cnt += 1, flush<=1, flush_pc<=jumpaddr, go to FLUSH.
  - FLUSH: flush held at 1. All EX resolution inputs are ignored (wrong path): no table update, no counting. On rdy, flush<=0 and go to IDLE. If rdy=0, stay in FLUSH with flush=1.
- Statistics counters saturate at 32'hFFFFFFFF and do not wrap.
- JALR is handled like any taken branch: it allocates and trains. EX always reports it as mispredicted.

## Timing
- Reset (rst=1 at an edge, regardless of rdy or state):
  - all valid=0, all ctr=2'b01;
  - state=IDLE, flush=0, flush_pc=0;
  - branch_cnt=0, mispred_cnt=0.
- Prediction has zero-cycle latency: it is valid in the same cycle as if_pc.
- Updates take effect at the edge ending the resolve cycle N. A lookup of the same index in cycle N sees the old contents; the new value is visible from N+1.
- Mispredict in cycle N (IDLE, rdy) gives flush=1 and flush_pc=jumpaddr during N+1 exactly. flush is 0 in N+2 if rdy stays 1.
- Back-to-back: a branch_flag in N+1 (FLUSH) is dropped. A branch_flag in N+2 is accepted normally.
- rst during FLUSH gives flush=0 on the next cycle. The table is cleared and the pending redirect is abandoned.
- rdy=0 in cycle N: the resolution is not captured, and EX is expected to hold it until rdy.

## Test plan
- Reset, then if_pc=0x1000 → pred_taken=0, pred_pc=0x1004; flush=0, both counters 0.
- Taken branch at 0x1000, target 0x0F00, prediction_res=0 → next cycle flush=1, flush_pc=0x0F00, mispred_cnt=1. Then if_pc=0x1000 → pred_taken=1, pred_pc=0x0F00.
- Same branch resolves not-taken twice from ctr=2 → ctr goes 1 then 0; pred_pc=0x1004. Three taken resolutions → ctr saturates at 3, and one not-taken still predicts taken.
- Alias: ENTRIES=64, entry installed at 0x1000; if_pc=0x1100 (same index, different tag) → miss, pred_pc=0x1104.
- Mispredict in cycle N plus branch_flag with prediction_res=0 in N+1 → single flush pulse; branch_cnt and mispred_cnt each advance by 1 only; the table is untouched by the N+1 input.
- rdy=0 throughout a mispredict → no flush and no counter change. rdy=0 while in FLUSH → flush stays 1 until the first rdy=1 cycle, then clears.
